// File: rtl/i2c_xfer_sequencer.sv
// rtl/i2c_xfer_sequencer.sv - WISHBONE master sequencing a byte-level I2C master core
//
// Turns one register-access request (write or single-byte read) into the
// full command sequence on the I2C core's register file, after first
// programming the prescaler and enabling the core out of reset.
//
// Ports:
//   wb_clk_i, arst_i (async, active-low)
//   req_*   : request handshake (valid/ready) with rnw, device, register, write data
//   rsp_*   : one-cycle completion pulse with read data and status
//               (00 ok, 01 NACK, 10 arbitration lost, 11 timeout)
//   busy_o  : high during init and from accept until the response pulse
//   m_*     : WISHBONE master toward the core (adr 0..4, 8-bit data)
//
// Optional: I2C_SEQ_TIMEOUT_EN bounds SR polling to TIMEOUT_POLLS reads per byte.

module i2c_xfer_sequencer #(
    parameter logic [15:0] PRESCALE      = 16'd99,
    parameter logic [15:0] TIMEOUT_POLLS = 16'd4096
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [6:0] req_dev_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    output logic       busy_o,
    output logic [2:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    output logic       m_we_o,
    output logic       m_stb_o,
    output logic       m_cyc_o,
    input  logic       m_ack_i
);

    typedef enum logic [3:0] {
        INIT_PLO, INIT_PHI, INIT_CTR, IDLE, WR_TXR, WR_CR,
        POLL_SR, CHK, RD_RXR, STOP_CR, STOP_POLL, RESP
    } state_t;

    state_t     state, state_n;
    logic [2:0] step_q, step_n;
    logic [1:0] err_q, err_n;
    logic       rnw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wdata_q;
    logic       sr_rxack_q, sr_al_q;
    logic       accept;
    logic       acc_req, acc_we;
    logic [2:0] acc_adr;
    logic [7:0] acc_dat;
    logic [7:0] txr_byte, cr_byte;
    logic       poll_limit;

    // An ack only counts while we are actually strobing.
    wire bus_ack = m_cyc_o & m_stb_o & m_ack_i;
    wire sr_tip  = m_dat_i[1];
    // The read-data step (read step 3) expects the master's own NACK in RxACK.
    wire rd_data_step = rnw_q && (step_q == 3'd3);

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt;

    // True on the SR read that would be the TIMEOUT_POLLS-th of this byte.
    assign poll_limit = (poll_cnt == TIMEOUT_POLLS - 16'd1);

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i)
            poll_cnt <= 16'd0;
        else if (state == WR_CR || state == STOP_CR)
            poll_cnt <= 16'd0;
        else if ((state == POLL_SR || state == STOP_POLL) && bus_ack)
            poll_cnt <= poll_cnt + 16'd1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_POLLS;
    assign poll_limit     = 1'b0;
`endif

    always_comb begin
        case (step_q)
            3'd0:    txr_byte = {dev_q, 1'b0};
            3'd1:    txr_byte = reg_q;
            default: txr_byte = rnw_q ? {dev_q, 1'b1} : wdata_q;
        endcase
        case (step_q)
            3'd0:    cr_byte = 8'h90;
            3'd1:    cr_byte = 8'h10;
            3'd2:    cr_byte = rnw_q ? 8'h90 : 8'h50;
            default: cr_byte = 8'h68;
        endcase
    end

    always_comb begin
        state_n = state;
        step_n  = step_q;
        err_n   = err_q;
        accept  = 1'b0;
        acc_req = 1'b0;
        acc_we  = 1'b0;
        acc_adr = 3'd0;
        acc_dat = 8'h00;
        case (state)
            INIT_PLO: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = 3'd0; acc_dat = PRESCALE[7:0];
                if (bus_ack) state_n = INIT_PHI;
            end
            INIT_PHI: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = 3'd1; acc_dat = PRESCALE[15:8];
                if (bus_ack) state_n = INIT_CTR;
            end
            INIT_CTR: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = 3'd2; acc_dat = 8'h80;
                if (bus_ack) state_n = IDLE;
            end
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    step_n  = 3'd0;
                    err_n   = 2'b00;
                    state_n = WR_TXR;
                end
            end
            WR_TXR: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = 3'd3; acc_dat = txr_byte;
                if (bus_ack) state_n = WR_CR;
            end
            WR_CR: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = 3'd4; acc_dat = cr_byte;
                if (bus_ack) state_n = POLL_SR;
            end
            POLL_SR: begin
                acc_req = 1'b1; acc_adr = 3'd4;
                if (bus_ack) begin
                    if (!sr_tip) begin
                        state_n = CHK;
                    end else if (poll_limit) begin
                        err_n   = 2'b11;
                        state_n = STOP_CR;
                    end
                end
            end
            CHK: begin
                if (sr_al_q) begin
                    err_n   = 2'b10;
                    state_n = RESP;
                end else if (sr_rxack_q && !rd_data_step) begin
                    err_n   = 2'b01;
                    state_n = STOP_CR;
                end else if (!rnw_q && step_q == 3'd2) begin
                    state_n = RESP;
                end else if (rd_data_step) begin
                    state_n = RD_RXR;
                end else begin
                    step_n  = step_q + 3'd1;
                    // The read-data step has no TXR byte to load.
                    state_n = (rnw_q && step_q == 3'd2) ? WR_CR : WR_TXR;
                end
            end
            RD_RXR: begin
                acc_req = 1'b1; acc_adr = 3'd3;
                if (bus_ack) state_n = RESP;
            end
            STOP_CR: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = 3'd4; acc_dat = 8'h40;
                // A timed-out byte gets its STOP command but no further polling.
                if (bus_ack) state_n = (err_q == 2'b11) ? RESP : STOP_POLL;
            end
            STOP_POLL: begin
                acc_req = 1'b1; acc_adr = 3'd4;
                if (bus_ack) begin
                    if (!sr_tip) begin
                        state_n = RESP;
                    end else if (poll_limit) begin
                        err_n   = 2'b11;
                        state_n = RESP;
                    end
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = INIT_PLO;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i)
            state <= INIT_PLO;
        else
            state <= state_n;
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            step_q      <= 3'd0;
            err_q       <= 2'b00;
            rnw_q       <= 1'b0;
            dev_q       <= 7'd0;
            reg_q       <= 8'h00;
            wdata_q     <= 8'h00;
            sr_rxack_q  <= 1'b0;
            sr_al_q     <= 1'b0;
            m_cyc_o     <= 1'b0;
            m_stb_o     <= 1'b0;
            m_we_o      <= 1'b0;
            m_adr_o     <= 3'd0;
            m_dat_o     <= 8'h00;
            rsp_rdata_o <= 8'h00;
            rsp_err_o   <= 2'b00;
        end else begin
            step_q <= step_n;
            err_q  <= err_n;
            if (accept) begin
                rnw_q   <= req_rnw_i;
                dev_q   <= req_dev_i;
                reg_q   <= req_reg_i;
                wdata_q <= req_wdata_i;
            end
            if (state == POLL_SR && bus_ack) begin
                sr_rxack_q <= m_dat_i[7];
                sr_al_q    <= m_dat_i[5];
            end
            // Drop the cycle right after the ack; a new access can only start
            // from an idle bus, which guarantees one idle cycle between accesses.
            if (m_cyc_o) begin
                if (m_ack_i) begin
                    m_cyc_o <= 1'b0;
                    m_stb_o <= 1'b0;
                    m_we_o  <= 1'b0;
                end
            end else if (acc_req) begin
                m_cyc_o <= 1'b1;
                m_stb_o <= 1'b1;
                m_we_o  <= acc_we;
                m_adr_o <= acc_adr;
                m_dat_o <= acc_dat;
            end
            if (state_n == RESP && state != RESP) begin
                rsp_rdata_o <= (state == RD_RXR) ? m_dat_i : 8'h00;
                rsp_err_o   <= err_n;
            end
        end
    end

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign busy_o      = (state != IDLE) && (state != RESP);

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb/tb_i2c_xfer_sequencer.sv - directed self-checking bench for i2c_xfer_sequencer

module tb_i2c_xfer_sequencer;

    logic       wb_clk_i = 1'b0;
    logic       arst_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_rnw_i = 1'b0;
    logic [6:0] req_dev_i = 7'd0;
    logic [7:0] req_reg_i = 8'h00;
    logic [7:0] req_wdata_i = 8'h00;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic [1:0] rsp_err_o;
    logic       busy_o;
    logic [2:0] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i = 8'h00;
    logic       m_we_o;
    logic       m_stb_o;
    logic       m_cyc_o;
    logic       m_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Core model state
    logic [10:0] wlog[$];
    int          cr_idx = -1;
    int          nack_at = -1;
    int          al_at = -1;
    int          polls_left = 0;
    int          sr_reads = 0;
    bit          tip_hold = 1'b0;
    bit          cur_nack = 1'b0;
    bit          cur_al = 1'b0;
    logic [7:0]  rxr_val = 8'h00;

    logic [7:0]  got_rdata;
    logic [1:0]  got_err;

    i2c_xfer_sequencer #(.PRESCALE(16'd99), .TIMEOUT_POLLS(16'd8)) dut (
        .wb_clk_i(wb_clk_i), .arst_i(arst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rnw_i(req_rnw_i),
        .req_dev_i(req_dev_i), .req_reg_i(req_reg_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // I2C core register-file model: acks every strobe half a cycle later.
    // Each CR write leaves TIP set for one SR read (or forever with tip_hold).
    always @(negedge wb_clk_i) begin
        if (!arst_i) begin
            m_ack_i = 1'b0;
        end else if (m_cyc_o && m_stb_o && !m_ack_i) begin
            m_ack_i = 1'b1;
            if (m_we_o) begin
                wlog.push_back({m_adr_o, m_dat_o});
                if (m_adr_o == 3'd4) begin
                    cr_idx++;
                    polls_left = 1;
                    cur_nack = (cr_idx == nack_at);
                    cur_al = (cr_idx == al_at);
                end
            end else if (m_adr_o == 3'd4) begin
                sr_reads++;
                m_dat_i = {cur_nack, 1'b0, cur_al, 3'b000, (tip_hold || polls_left > 0), 1'b0};
                if (polls_left > 0) polls_left--;
            end else if (m_adr_o == 3'd3) begin
                m_dat_i = rxr_val;
            end else begin
                m_dat_i = 8'hEE;
            end
        end else begin
            m_ack_i = 1'b0;
        end
    end

    task automatic prep(input int nack, input int al);
        wlog.delete();
        cr_idx = -1;
        nack_at = nack;
        al_at = al;
        sr_reads = 0;
    endtask

    task automatic send(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
        bit ok;
        ok = 1'b0;
        @(negedge wb_clk_i);
        req_rnw_i = rnw; req_dev_i = dev; req_reg_i = rg; req_wdata_i = wd;
        req_valid_i = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (req_ready_o) begin ok = 1'b1; break; end
            @(negedge wb_clk_i);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept ready never seen got %0b exp 1", req_ready_o);
        end
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge wb_clk_i); #1;
            if (rsp_valid_o) begin
                got = 1'b1;
                got_rdata = rsp_rdata_o;
                got_err = rsp_err_o;
                break;
            end
        end
    endtask

    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge wb_clk_i); #1;
            if (req_ready_o) begin got = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        bit got;
        logic [10:0] ex[$];
        ex = '{{3'd0, 8'h63}, {3'd0 + 3'd1, 8'h00}, {3'd2, 8'h80}};
        prep(-1, -1);
        arst_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        checks++;
        if ({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, req_ready_o, rsp_valid_o,
             rsp_rdata_o, rsp_err_o, busy_o} !== {3'b000, 3'd0, 8'h00, 2'b00, 8'h00, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs got cyc=%b adr=%h dat=%h rdy=%b rv=%b rd=%h err=%b busy=%b exp zeros busy=1",
                     m_cyc_o, m_adr_o, m_dat_o, req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o);
        end
        @(negedge wb_clk_i);
        arst_i = 1'b1;
        wait_ready(got);
        checks++;
        if (!got || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL init_done got ready=%b busy=%b exp ready=1 busy=0", req_ready_o, busy_o);
        end
        checks++;
        if (wlog.size() != ex.size()) begin
            errors++;
            $display("FAIL init_count got %0d exp %0d", wlog.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== ex[i]) begin
                errors++;
                $display("FAIL init_write%0d got %h exp %h", i, wlog[i], ex[i]);
            end
        end
    endtask

    task automatic test_write;
        bit got;
        logic [10:0] ex[$];
        ex = '{{3'd3, 8'hA0}, {3'd4, 8'h90}, {3'd3, 8'h12}, {3'd4, 8'h10},
               {3'd3, 8'hA5}, {3'd4, 8'h50}};
        prep(-1, -1);
        send(1'b0, 7'h50, 8'h12, 8'hA5);
        checks++;
        if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL write_accept got ready=%b busy=%b exp ready=0 busy=1", req_ready_o, busy_o);
        end
        wait_rsp(got);
        checks++;
        if (!got || got_err !== 2'b00 || got_rdata !== 8'h00 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp got v=%b err=%b rd=%h busy=%b exp v=1 err=00 rd=00 busy=0",
                     got, got_err, got_rdata, busy_o);
        end
        @(posedge wb_clk_i); #1;
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse_width got %b exp 0", rsp_valid_o);
        end
        checks++;
        if (wlog.size() != ex.size()) begin
            errors++;
            $display("FAIL write_count got %0d exp %0d", wlog.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== ex[i]) begin
                errors++;
                $display("FAIL write_seq%0d got %h exp %h", i, wlog[i], ex[i]);
            end
        end
    endtask

    task automatic test_read;
        bit got;
        logic [10:0] ex[$];
        ex = '{{3'd3, 8'hA0}, {3'd4, 8'h90}, {3'd3, 8'h34}, {3'd4, 8'h10},
               {3'd3, 8'hA1}, {3'd4, 8'h90}, {3'd4, 8'h68}};
        prep(-1, -1);
        rxr_val = 8'h5A;
        send(1'b1, 7'h50, 8'h34, 8'h00);
        wait_rsp(got);
        checks++;
        if (!got || got_err !== 2'b00 || got_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL read_rsp got v=%b err=%b rd=%h exp v=1 err=00 rd=5a", got, got_err, got_rdata);
        end
        repeat (3) @(posedge wb_clk_i);
        #1;
        checks++;
        if (rsp_rdata_o !== 8'h5A) begin
            errors++;
            $display("FAIL read_hold got %h exp 5a", rsp_rdata_o);
        end
        checks++;
        if (wlog.size() != ex.size()) begin
            errors++;
            $display("FAIL read_count got %0d exp %0d", wlog.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== ex[i]) begin
                errors++;
                $display("FAIL read_seq%0d got %h exp %h", i, wlog[i], ex[i]);
            end
        end
    endtask

    task automatic test_nack;
        bit got;
        logic [10:0] ex[$];
        ex = '{{3'd3, 8'hA0}, {3'd4, 8'h90}, {3'd4, 8'h40}};
        prep(0, -1);
        send(1'b0, 7'h50, 8'h12, 8'h77);
        wait_rsp(got);
        checks++;
        if (!got || got_err !== 2'b01 || got_rdata !== 8'h00) begin
            errors++;
            $display("FAIL nack_rsp got v=%b err=%b rd=%h exp v=1 err=01 rd=00", got, got_err, got_rdata);
        end
        checks++;
        if (wlog.size() != ex.size()) begin
            errors++;
            $display("FAIL nack_count got %0d exp %0d", wlog.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== ex[i]) begin
                errors++;
                $display("FAIL nack_seq%0d got %h exp %h", i, wlog[i], ex[i]);
            end
        end
    endtask

    task automatic test_arb_lost;
        bit got;
        logic [10:0] ex[$];
        ex = '{{3'd3, 8'hA0}, {3'd4, 8'h90}, {3'd3, 8'h12}, {3'd4, 8'h10}};
        prep(1, 1);
        send(1'b0, 7'h50, 8'h12, 8'h33);
        wait_rsp(got);
        checks++;
        if (!got || got_err !== 2'b10) begin
            errors++;
            $display("FAIL al_rsp got v=%b err=%b exp v=1 err=10", got, got_err);
        end
        checks++;
        if (wlog.size() != ex.size()) begin
            errors++;
            $display("FAIL al_count got %0d exp %0d", wlog.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== ex[i]) begin
                errors++;
                $display("FAIL al_seq%0d got %h exp %h", i, wlog[i], ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit got;
        logic [10:0] ex[$];
        ex = '{{3'd3, 8'h42}, {3'd4, 8'h90}, {3'd3, 8'h01}, {3'd4, 8'h10},
               {3'd3, 8'h3C}, {3'd4, 8'h50}};
        prep(-1, -1);
        send(1'b0, 7'h11, 8'h02, 8'h03);
        wait_rsp(got);
        // Present the next request during the RESP cycle.
        req_rnw_i = 1'b0; req_dev_i = 7'h21; req_reg_i = 8'h01; req_wdata_i = 8'h3C;
        req_valid_i = 1'b1;
        @(posedge wb_clk_i); #1;
        checks++;
        if (!got || req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got v=%b ready=%b exp v=1 ready=1", got, req_ready_o);
        end
        @(posedge wb_clk_i); #1;
        req_valid_i = 1'b0;
        checks++;
        if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got ready=%b busy=%b exp ready=0 busy=1", req_ready_o, busy_o);
        end
        prep(-1, -1);
        wait_rsp(got);
        checks++;
        if (!got || got_err !== 2'b00) begin
            errors++;
            $display("FAIL b2b_rsp got v=%b err=%b exp v=1 err=00", got, got_err);
        end
        checks++;
        if (wlog.size() != ex.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d exp %0d", wlog.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== ex[i]) begin
                errors++;
                $display("FAIL b2b_seq%0d got %h exp %h", i, wlog[i], ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit got;
        bit polled;
        logic [10:0] ex[$];
        ex = '{{3'd0, 8'h63}, {3'd1, 8'h00}, {3'd2, 8'h80}};
        prep(-1, -1);
        tip_hold = 1'b1;
        send(1'b1, 7'h50, 8'h34, 8'h00);
        polled = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge wb_clk_i);
            if (sr_reads >= 3) begin polled = 1'b1; break; end
        end
        checks++;
        if (!polled) begin
            errors++;
            $display("FAIL mid_poll got sr_reads=%0d exp >=3", sr_reads);
        end
        @(posedge wb_clk_i); #2;
        arst_i = 1'b0;
        #1;
        checks++;
        if ({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, busy_o, req_ready_o} !== {3'b000, 3'd0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_bus got cyc=%b stb=%b adr=%h dat=%h busy=%b exp zeros busy=1",
                     m_cyc_o, m_stb_o, m_adr_o, m_dat_o, busy_o);
        end
        repeat (2) @(negedge wb_clk_i);
        tip_hold = 1'b0;
        prep(-1, -1);
        arst_i = 1'b1;
        wait_ready(got);
        checks++;
        if (!got || wlog.size() != ex.size()) begin
            errors++;
            $display("FAIL mid_reinit got ready=%b writes=%0d exp ready=1 writes=%0d", got, wlog.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== ex[i]) begin
                errors++;
                $display("FAIL mid_reinit%0d got %h exp %h", i, wlog[i], ex[i]);
            end
        end
    endtask

`ifdef I2C_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        bit got;
        logic [10:0] ex[$];
        ex = '{{3'd3, 8'hA0}, {3'd4, 8'h90}, {3'd4, 8'h40}};
        prep(-1, -1);
        tip_hold = 1'b1;
        send(1'b0, 7'h50, 8'h12, 8'hA5);
        wait_rsp(got);
        tip_hold = 1'b0;
        checks++;
        if (!got || got_err !== 2'b11) begin
            errors++;
            $display("FAIL timeout_rsp got v=%b err=%b exp v=1 err=11", got, got_err);
        end
        checks++;
        if (sr_reads != 8) begin
            errors++;
            $display("FAIL timeout_polls got %0d exp 8", sr_reads);
        end
        checks++;
        if (wlog.size() != ex.size()) begin
            errors++;
            $display("FAIL timeout_count got %0d exp %0d", wlog.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== ex[i]) begin
                errors++;
                $display("FAIL timeout_seq%0d got %h exp %h", i, wlog[i], ex[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_arb_lost();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
